// File: rtl/scpu_pkg.sv
// scpu_pkg: shared opcode/funct/ALUop/ALU_Control encodings, FSM state type, funct validity helper
package scpu_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_J = 6'h02;
  localparam logic [5:0] OP_SLTI = 6'h24, OP_SLTI_ALT = 6'h0a;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100, FN_OR = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010, FN_NOR = 6'b100111, FN_SRL = 6'b000010;
  localparam logic [5:0] FN_XOR = 6'b100110, FN_XOR_ALT = 6'b010110;
  localparam logic [1:0] ALUOP_MEM = 2'b00, ALUOP_BEQ = 2'b01, ALUOP_R = 2'b10, ALUOP_SLTI = 2'b11;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010, ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100, ALU_SRL = 3'b101, ALU_SUB = 3'b110, ALU_SLT = 3'b111;
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  function automatic logic fun_valid(input logic [5:0] f);
    return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR, FN_SRL, FN_XOR, FN_XOR_ALT};
  endfunction
endpackage

// File: rtl/scpu_alu_dec.sv
// scpu_alu_dec: ALUop + funct -> ALU_Control (alu_op_i[1:0], fun_i[5:0] in; alu_ctrl_o[2:0] out)
module scpu_alu_dec
  import scpu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] fun_i,
  output logic [2:0] alu_ctrl_o
);
  logic [2:0] r_ctrl;
  always_comb begin
    r_ctrl = ALU_ADD;
    case (fun_i)
      FN_ADD:             r_ctrl = ALU_ADD;
      FN_SUB:             r_ctrl = ALU_SUB;
      FN_AND:             r_ctrl = ALU_AND;
      FN_OR:              r_ctrl = ALU_OR;
      FN_SLT:             r_ctrl = ALU_SLT;
      FN_NOR:             r_ctrl = ALU_NOR;
      FN_SRL:             r_ctrl = ALU_SRL;
      FN_XOR, FN_XOR_ALT: r_ctrl = ALU_XOR;
      default:            r_ctrl = ALU_ADD;
    endcase
  end
  assign alu_ctrl_o = alu_op_i == ALUOP_R    ? r_ctrl :
                      alu_op_i == ALUOP_BEQ  ? ALU_SUB :
                      alu_op_i == ALUOP_SLTI ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/scpu_ctrl.sv
// scpu_ctrl: single-cycle CPU control decode with memory-ready stall FSM (clk, rst, OPcode, Fun, MIO_ready in; datapath selects, enables, ALU_Control, CPU_MIO, stall out)
module scpu_ctrl
  import scpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       MIO_ready,
  output logic       RegDst,
  output logic       ALUSrc_B,
  output logic       MemtoReg,
  output logic       Jump,
  output logic       Branch,
  output logic       RegWrite,
  output logic       mem_w,
  output logic [2:0] ALU_Control,
  output logic       CPU_MIO,
  output logic       stall
);
  state_e state_q, state_d;
  logic is_r, is_lw, is_sw, is_beq, is_j, is_slti, is_mem, wait_mem;
  logic [1:0] alu_op;
  logic [2:0] alu_ctrl;
  assign is_r     = OPcode == OP_R;
  assign is_lw    = OPcode == OP_LW;
  assign is_sw    = OPcode == OP_SW;
  assign is_beq   = OPcode == OP_BEQ;
  assign is_j     = OPcode == OP_J;
  assign is_slti  = OPcode == OP_SLTI || OPcode == OP_SLTI_ALT;
  assign is_mem   = is_lw || is_sw;
  assign wait_mem = is_mem && !MIO_ready;
  assign alu_op   = is_r ? ALUOP_R : is_beq ? ALUOP_BEQ : is_slti ? ALUOP_SLTI : ALUOP_MEM;
  scpu_alu_dec u_alu_dec (.alu_op_i(alu_op), .fun_i(Fun), .alu_ctrl_o(alu_ctrl));
  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
  // Outputs are a pure function of the current instruction; the FSM only tracks the pending access.
  always_comb begin
    state_d     = state_q == S_IDLE ? (wait_mem ? S_WAIT : S_IDLE) : (wait_mem ? S_WAIT : S_IDLE);
    RegDst      = !rst && is_r;
    ALUSrc_B    = !rst && (is_mem || is_slti);
    MemtoReg    = !rst && is_lw;
    Jump        = !rst && is_j;
    Branch      = !rst && is_beq;
    RegWrite    = !rst && !wait_mem && ((is_r && fun_valid(Fun)) || is_lw || is_slti);
    mem_w       = !rst && !wait_mem && is_sw;
    CPU_MIO     = !rst && is_mem;
    stall       = !rst && wait_mem;
    ALU_Control = rst ? 3'b000 : alu_ctrl;
  end
endmodule

// File: tb/tb_scpu_ctrl.sv
// tb_scpu_ctrl: table-driven and sequence checks of scpu_ctrl through an expected-value queue
module tb_scpu_ctrl;
  import scpu_pkg::*;
  logic clk = 0, rst = 1, MIO_ready = 0;
  logic [5:0] OPcode = 0, Fun = 0;
  logic RegDst, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite, mem_w, CPU_MIO, stall;
  logic [2:0] ALU_Control;
  int n_checks = 0, n_fail = 0;
  logic [11:0] sb[$];
  typedef struct {
    logic rst;
    logic [5:0] op;
    logic [5:0] fun;
    logic rdy;
    logic [11:0] exp;
  } vec_t;
  vec_t tv[$];
  scpu_ctrl dut (.clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .MIO_ready(MIO_ready),
    .RegDst(RegDst), .ALUSrc_B(ALUSrc_B), .MemtoReg(MemtoReg), .Jump(Jump), .Branch(Branch),
    .RegWrite(RegWrite), .mem_w(mem_w), .ALU_Control(ALU_Control), .CPU_MIO(CPU_MIO), .stall(stall));
  always #5 clk = ~clk;
  wire [11:0] outs = {RegDst, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite, mem_w, CPU_MIO, stall, ALU_Control};
  function automatic logic [11:0] e(input logic rd, as, mr, j, b, rw, mw, mio, st, input logic [2:0] alu);
    return {rd, as, mr, j, b, rw, mw, mio, st, alu};
  endfunction
  function automatic vec_t mk(input logic r, input logic [5:0] op, fun, input logic rdy, input logic [11:0] ex);
    vec_t v;
    v.rst = r; v.op = op; v.fun = fun; v.rdy = rdy; v.exp = ex;
    return v;
  endfunction
  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic apply(input string name, input vec_t v);
    @(negedge clk);
    rst = v.rst; OPcode = v.op; Fun = v.fun; MIO_ready = v.rdy;
    sb.push_back(v.exp);
    #2;
    check(name, outs, sb.pop_front());
  endtask
  task automatic check_state(input string name, input logic exp_wait);
    @(posedge clk);
    #1;
    check(name, {11'b0, dut.state_q == S_WAIT}, {11'b0, exp_wait});
  endtask
  initial begin
    tv.push_back(mk(0, 6'h00, 6'b100000, 1, e(1,0,0,0,0,1,0,0,0,3'b010)));
    tv.push_back(mk(0, 6'h00, 6'b100010, 1, e(1,0,0,0,0,1,0,0,0,3'b110)));
    tv.push_back(mk(0, 6'h00, 6'b100100, 0, e(1,0,0,0,0,1,0,0,0,3'b000)));
    tv.push_back(mk(0, 6'h00, 6'b100101, 1, e(1,0,0,0,0,1,0,0,0,3'b001)));
    tv.push_back(mk(0, 6'h00, 6'b101010, 1, e(1,0,0,0,0,1,0,0,0,3'b111)));
    tv.push_back(mk(0, 6'h00, 6'b100111, 0, e(1,0,0,0,0,1,0,0,0,3'b100)));
    tv.push_back(mk(0, 6'h00, 6'b000010, 1, e(1,0,0,0,0,1,0,0,0,3'b101)));
    tv.push_back(mk(0, 6'h00, 6'b010110, 1, e(1,0,0,0,0,1,0,0,0,3'b011)));
    tv.push_back(mk(0, 6'h00, 6'b100110, 1, e(1,0,0,0,0,1,0,0,0,3'b011)));
    tv.push_back(mk(0, 6'h00, 6'b111111, 1, e(1,0,0,0,0,0,0,0,0,3'b010)));
    tv.push_back(mk(0, 6'h23, 6'b000000, 1, e(0,1,1,0,0,1,0,1,0,3'b010)));
    tv.push_back(mk(0, 6'h23, 6'b000000, 0, e(0,1,1,0,0,0,0,1,1,3'b010)));
    tv.push_back(mk(0, 6'h2b, 6'b101010, 1, e(0,1,0,0,0,0,1,1,0,3'b010)));
    tv.push_back(mk(0, 6'h2b, 6'b101010, 0, e(0,1,0,0,0,0,0,1,1,3'b010)));
    tv.push_back(mk(0, 6'h04, 6'b100000, 0, e(0,0,0,0,1,0,0,0,0,3'b110)));
    tv.push_back(mk(0, 6'h02, 6'b000000, 0, e(0,0,0,1,0,0,0,0,0,3'b010)));
    tv.push_back(mk(0, 6'h24, 6'b100010, 1, e(0,1,0,0,0,1,0,0,0,3'b111)));
    tv.push_back(mk(0, 6'h0a, 6'b000000, 0, e(0,1,0,0,0,1,0,0,0,3'b111)));
    tv.push_back(mk(0, 6'h3f, 6'b111111, 0, e(0,0,0,0,0,0,0,0,0,3'b010)));
    tv.push_back(mk(1, 6'h23, 6'b000000, 0, 12'b0));
    tv.push_back(mk(1, 6'h00, 6'b101010, 1, 12'b0));
    tv.push_back(mk(1, 6'h24, 6'b111111, 1, 12'b0));
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs, 12'b0);
    check("reset_state", {11'b0, dut.state_q == S_WAIT}, 12'b0);
    foreach (tv[i]) apply($sformatf("vec%0d", i), tv[i]);
    apply("seq_sw_rst", mk(1, 6'h00, 6'h00, 1, 12'b0));
    check_state("seq_sw_idle0", 0);
    for (int c = 0; c < 2; c++) begin
      apply($sformatf("seq_sw_wait%0d", c), mk(0, 6'h2b, 6'h00, 0, e(0,1,0,0,0,0,0,1,1,3'b010)));
      check_state($sformatf("seq_sw_state_wait%0d", c), 1);
    end
    apply("seq_sw_ready", mk(0, 6'h2b, 6'h00, 1, e(0,1,0,0,0,0,1,1,0,3'b010)));
    check_state("seq_sw_state_idle", 0);
    apply("seq_abort_wait", mk(0, 6'h23, 6'h00, 0, e(0,1,1,0,0,0,0,1,1,3'b010)));
    check_state("seq_abort_state_wait", 1);
    apply("seq_abort_new", mk(0, 6'h00, 6'b100010, 0, e(1,0,0,0,0,1,0,0,0,3'b110)));
    check_state("seq_abort_state_idle", 0);
    apply("seq_rst_wait", mk(0, 6'h2b, 6'h00, 0, e(0,1,0,0,0,0,0,1,1,3'b010)));
    check_state("seq_rst_state_wait", 1);
    apply("seq_rst_assert", mk(1, 6'h2b, 6'h00, 0, 12'b0));
    check_state("seq_rst_state_idle", 0);
    apply("seq_rst_release", mk(0, 6'h2b, 6'h00, 1, e(0,1,0,0,0,0,1,1,0,3'b010)));
    check_state("seq_rst_state_stay", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/scpu_ctrl.md
SCPU_CTRL -- requirements
Module: scpu_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 OPcode  input  6  instruction bits [31:26].
REQ-005 Fun  input  6  instruction bits [5:0] (R-type funct).
REQ-006 MIO_ready  input  1  memory/IO ready handshake.
REQ-007 RegDst  output  1  selects rd (1) or rt (0) as the write register.
REQ-008 ALUSrc_B  output  1  selects immediate (1) or rt (0) as ALU operand B.
REQ-009 MemtoReg  output  1  selects memory data (1) or ALU result (0) for write-back.
REQ-010 Jump  output  1  j instruction.
REQ-011 Branch  output  1  beq instruction.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 mem_w  output  1  memory write enable.
REQ-014 ALU_Control  output  3  ALU operation code.
REQ-015 CPU_MIO  output  1  CPU requests a memory/IO access.
REQ-016 stall  output  1  memory access pending; the PC must hold.

Function
REQ-017 The decode SHALL be combinational, with zero-cycle latency from OPcode/Fun to every output while rst=0.
REQ-018 Internal ALUop (2 bits) SHALL be:
- R-type: 10
- lw/sw: 00
- beq: 01
- slti: 11
- all other opcodes: 00
REQ-019 OPcode 000000 (R-type) SHALL set RegDst=1, RegWrite=1, and all other 1-bit outputs 0.
REQ-020 R-type Fun SHALL map to ALU_Control as follows:
- 100000 (add) -> 010
- 100010 (sub) -> 110
- 100100 (and) -> 000
- 100101 (or) -> 001
- 101010 (slt) -> 111
- 100111 (nor) -> 100
- 000010 (srl) -> 101
- 100110 or 010110 (xor) -> 011
REQ-021 An undefined R-type Fun SHALL give ALU_Control=010 and RegWrite=0 (no architectural effect).
REQ-022 OPcode 100011 (lw) SHALL set ALUSrc_B=1, MemtoReg=1, RegWrite=1, CPU_MIO=1, RegDst=0, ALU_Control=010.
REQ-023 OPcode 101011 (sw) SHALL set ALUSrc_B=1, mem_w=1, CPU_MIO=1, RegWrite=0, ALU_Control=010.
REQ-024 OPcode 000100 (beq) SHALL set Branch=1, ALU_Control=110, RegWrite=0.
REQ-025 OPcode 000010 (j) SHALL set Jump=1, all other 1-bit outputs 0, ALU_Control=010.
REQ-026 OPcode 6'h24 and 6'h0A (slti) SHALL set ALUSrc_B=1, RegWrite=1, RegDst=0, ALU_Control=111.
REQ-027 Any other OPcode SHALL drive all 1-bit outputs 0 and ALU_Control=010.
REQ-028 Memory handshake: for lw/sw with MIO_ready=0, stall SHALL be 1 and RegWrite and mem_w SHALL be forced to 0; CPU_MIO remains 1.
REQ-029 A two-state FSM (IDLE, WAIT) SHALL be registered on clk:
- IDLE -> WAIT on lw/sw with MIO_ready=0.
- WAIT -> IDLE on MIO_ready=1; in that same cycle outputs are unsuppressed and stall=0.
- Any other condition holds the current state.
REQ-030 In WAIT, if OPcode is no longer lw/sw, the next state SHALL be IDLE (abort) and the outputs SHALL follow the new decode.
REQ-031 Non-memory instructions SHALL ignore MIO_ready and never assert stall.

Reset
REQ-032 While rst=1, all outputs SHALL be 0 and ALU_Control SHALL be 000, regardless of inputs.
REQ-033 On a clock edge with rst=1 the FSM SHALL enter IDLE; reset during WAIT SHALL abandon the pending access.

Structure
REQ-034 Opcode, funct, ALUop and ALU_Control encodings SHALL be constants in a shared package (scpu_pkg), together with the FSM state type.
REQ-035 The block SHALL contain one sub-module, scpu_alu_dec (ALUop, Fun -> ALU_Control); the main decode and FSM stay in scpu_ctrl.

Verification
REQ-036 rst=0, OPcode=0, Fun stepped through 100000/100010/100100/100101/101010/100111/000010/010110 -> ALU_Control 010/110/000/001/111/100/101/011, with RegDst=1 and RegWrite=1 throughout.
REQ-037 OPcode=100011 with MIO_ready=1 -> ALUSrc_B=1, MemtoReg=1, RegWrite=1, CPU_MIO=1, stall=0.
REQ-038 OPcode=101011 with MIO_ready=0 for 2 cycles then 1 -> stall=1 and mem_w=0 for 2 cycles (state WAIT), then mem_w=1, stall=0, state IDLE.
REQ-039 OPcode 000100 / 000010 / 6'h24 -> Branch=1 with ALU 110 / Jump=1 / ALUSrc_B=1, RegWrite=1, ALU 111.
REQ-040 OPcode=6'h3f with Fun=111111 -> all 1-bit outputs 0 and ALU_Control=010; and rst=1 with any inputs -> all outputs 0.
